// File: rtl/corrimiento_ctrl.sv
// Pattern sequencer for the LED-bar bidirectional shifter.
// Plays fill-left, fill-right or bouncing-dot through prescaled shift strobes.
module corrimiento_ctrl #(
  parameter int WIDTH  = 10,
  parameter int DIV    = 25000000,
  parameter int SWEEPS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [1:0]                 mode,
  output logic                       sh_enable,
  output logic                       sh_dir,
  output logic                       sh_in,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic [$clog2(WIDTH+1)-1:0] step
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NW = $clog2(SWEEPS + 1);

  localparam logic [CW-1:0] CNT_TOP = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = (DIV == 1) ? '0 : CW'(1);
  localparam logic [SW-1:0] LAST_W  = SW'(WIDTH - 1);
  localparam logic [SW-1:0] LAST_S  = SW'(WIDTH - 2);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_DRAIN,
    S_INJECT,
    S_RIGHT,
    S_LEFT,
    S_BCLR,
    S_DONE,
    S_ABORT
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [SW-1:0]   step_n, lastc;
  logic [NW-1:0]   sweep, sweep_n, sweep_inc;
  logic            bnc, bnc_n, rgt, rgt_n;
  logic            last, run_n, dir_n, in_n;

  always_comb begin
    lastc = LAST_W;
    unique case (state)
      S_INJECT, S_BCLR: lastc = '0;
      S_RIGHT, S_LEFT:  lastc = LAST_S;
      default:          lastc = LAST_W;
    endcase
  end

  assign last      = sh_enable && (step == lastc);
  assign sweep_inc = sweep + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = (cnt == CNT_TOP) ? '0 : cnt + 1'b1;
    sweep_n = sweep;
    bnc_n   = bnc;
    rgt_n   = rgt;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (start && !stop) begin
          state_n = S_CLEAR;
          cnt_n   = CNT_ONE;
          sweep_n = '0;
          bnc_n   = mode[1];
          rgt_n   = ~mode[1] & mode[0];
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      S_ABORT: begin
        if (last) state_n = S_IDLE;
      end
      default: begin
        if (stop) begin
          // the stop cycle counts as prescaler zero
          state_n = S_ABORT;
          cnt_n   = CNT_ONE;
        end else if (last) begin
          unique case (state)
            S_CLEAR:  state_n = bnc ? S_INJECT : S_FILL;
            S_FILL:   state_n = S_DRAIN;
            S_DRAIN:  state_n = S_DONE;
            S_INJECT: state_n = S_RIGHT;
            S_RIGHT:  state_n = S_LEFT;
            S_LEFT: begin
              sweep_n = sweep_inc;
              state_n = (sweep_inc < NW'(SWEEPS)) ? S_RIGHT : S_BCLR;
            end
            default:  state_n = S_DONE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    step_n = step;
    if (state_n != state) step_n = '0;
    else if (sh_enable)   step_n = step + 1'b1;
  end

  always_comb begin
    run_n = !(state_n inside {S_IDLE, S_DONE});
    dir_n = 1'b0;
    in_n  = 1'b0;
    unique case (state_n)
      S_CLEAR, S_DRAIN: dir_n = ~rgt_n;
      S_FILL: begin
        dir_n = ~rgt_n;
        in_n  = 1'b1;
      end
      S_INJECT: begin
        dir_n = 1'b1;
        in_n  = 1'b1;
      end
      S_RIGHT, S_ABORT: dir_n = 1'b1;
      default: begin
        dir_n = 1'b0;
        in_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      step      <= '0;
      sweep     <= '0;
      bnc       <= 1'b0;
      rgt       <= 1'b0;
      sh_enable <= 1'b0;
      sh_dir    <= 1'b0;
      sh_in     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      step      <= step_n;
      sweep     <= sweep_n;
      bnc       <= bnc_n;
      rgt       <= rgt_n;
      sh_enable <= run_n && (cnt_n == '0);
      sh_dir    <= dir_n;
      sh_in     <= in_n;
      busy      <= run_n;
      done      <= (state_n == S_DONE);
      aborted   <= (state == S_ABORT) && last;
    end
  end

endmodule

// File: tb/tb_corrimiento_ctrl.sv
// Bench for corrimiento_ctrl: behavioural shifter plus a strobe scoreboard.
// Cycle numbers are relative to the cycle in which start is held high.
module tb_corrimiento_ctrl;

  localparam int W = 10;
  localparam int D = 2;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst, start, stop;
  logic [1:0]   mode;
  logic         sh_enable, sh_dir, sh_in, busy, done, aborted;
  logic [3:0]   step;

  always #5 clk = ~clk;

  corrimiento_ctrl #(.WIDTH(W), .DIV(D), .SWEEPS(S)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .sh_enable(sh_enable), .sh_dir(sh_dir), .sh_in(sh_in),
    .busy(busy), .done(done), .aborted(aborted), .step(step)
  );

  typedef struct {int c; logic d; logic i;} strb_t;
  typedef struct {int idx; logic [W-1:0] v;} chk_t;

  strb_t        exp_q[$];
  chk_t         chk_q[$];
  strb_t        e;
  chk_t         ck;
  int           cyc = 0, t0 = 0, base = 0, nk = 0;
  int           errors = 0, checks = 0;
  int           nstr = 0, done_cnt = 0, ab_cnt = 0, busy_cnt = 0;
  int           d0, a0, b0, n0;
  logic [W-1:0] shreg = '0;

  // shifter model: dir=1 enters at bit 0, dir=0 enters at bit W-1
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sh_enable === 1'b1) begin
      nstr  <= nstr + 1;
      shreg <= sh_dir ? {shreg[W-2:0], sh_in} : {sh_in, shreg[W-1:1]};
    end
  end

  always @(negedge clk) begin
    if (sh_enable === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_extra: cycle %0d dir=%b in=%b, none expected",
                 cyc - t0, sh_dir, sh_in);
      end else begin
        e = exp_q.pop_front();
        if ({cyc - t0, sh_dir, sh_in} !== {e.c, e.d, e.i}) begin
          errors++;
          $display("FAIL strobe: got cycle %0d dir=%b in=%b, want cycle %0d dir=%b in=%b",
                   cyc - t0, sh_dir, sh_in, e.c, e.d, e.i);
        end
      end
    end
    if (chk_q.size() > 0 && chk_q[0].idx == nstr) begin
      ck = chk_q.pop_front();
      checks++;
      if (shreg !== ck.v) begin
        errors++;
        $display("FAIL out_after_strobe_%0d: got %h want %h", ck.idx - base, shreg, ck.v);
      end
    end
    if (done === 1'b1)    done_cnt++;
    if (aborted === 1'b1) ab_cnt++;
    if (busy === 1'b1)    busy_cnt++;
  end

  task automatic begin_scn();
    base = nstr;
    nk   = 0;
    exp_q.delete();
    chk_q.delete();
  endtask

  task automatic push_seq(input int n, input logic d, input logic i);
    for (int j = 0; j < n; j++) begin
      nk++;
      exp_q.push_back('{nk * D, d, i});
    end
  endtask

  task automatic push_chk(input int k, input logic [W-1:0] v);
    chk_q.push_back('{base + k, v});
  endtask

  task automatic go(input logic [1:0] m);
    @(posedge clk); #1;
    mode  = m;
    start = 1'b1;
    t0    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = ~m;
  endtask

  task automatic to_rel(input int r);
    while (cyc - t0 < r) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic at_rel(input int r);
    while (1) begin
      @(negedge clk);
      if (cyc - t0 >= r) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc;
    at_rel(1);
    checks++;
    if ({busy, done, aborted, sh_enable, sh_dir, sh_in, step} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {busy, done, aborted, sh_enable, sh_dir, sh_in, step});
    end
    at_rel(6);
    checks++;
    if (nstr !== 0 || busy_cnt !== 0) begin
      errors++;
      $display("FAIL reset_idle: strobes=%0d busy_cycles=%0d want 0 0", nstr, busy_cnt);
    end
  endtask

  task automatic test_fill(input logic [1:0] m);
    logic dr;
    dr = ~m[0];
    begin_scn();
    push_seq(W, dr, 1'b0);
    push_seq(W, dr, 1'b1);
    push_seq(W, dr, 1'b0);
    push_chk(10, '0);
    push_chk(11, m[0] ? 10'h200 : 10'h001);
    push_chk(20, 10'h3FF);
    push_chk(30, '0);
    d0 = done_cnt;
    go(m);
    at_rel(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL fill%0d_busy: got %b want 1", m, busy);
    end
    at_rel(5);
    checks++;
    if (step !== 4'd2) begin
      errors++;
      $display("FAIL fill%0d_step5: got %0d want 2", m, step);
    end
    at_rel(21);
    checks++;
    if (step !== 4'd0) begin
      errors++;
      $display("FAIL fill%0d_step21: got %0d want 0", m, step);
    end
    at_rel(61);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fill%0d_done61: got done=%b busy=%b want 1 0", m, done, busy);
    end
    at_rel(62);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL fill%0d_idle62: done=%b busy=%b pulses=%0d want 0 0 1",
               m, done, busy, done_cnt - d0);
    end
    checks++;
    if (exp_q.size() != 0 || chk_q.size() != 0) begin
      errors++;
      $display("FAIL fill%0d_left: strobes=%0d checks=%0d want 0 0",
               m, exp_q.size(), chk_q.size());
    end
  endtask

  task automatic test_bounce();
    begin_scn();
    push_seq(W, 1'b1, 1'b0);
    push_seq(1, 1'b1, 1'b1);
    for (int s = 0; s < S; s++) begin
      push_seq(W - 1, 1'b1, 1'b0);
      push_seq(W - 1, 1'b0, 1'b0);
    end
    push_seq(1, 1'b0, 1'b0);
    push_chk(11, 10'h001);
    push_chk(20, 10'h200);
    push_chk(29, 10'h001);
    push_chk(48, '0);
    d0 = done_cnt;
    go(2'b10);
    at_rel(97);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce_done97: got done=%b busy=%b want 1 0", done, busy);
    end
    at_rel(98);
    checks++;
    if (nstr - base != 48 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_total: strobes=%0d pulses=%0d want 48 1", nstr - base, done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    begin_scn();
    push_seq(7, 1'b1, 1'b0);
    for (int j = 0; j < W; j++) exp_q.push_back('{17 + 2 * j, 1'b1, 1'b0});
    push_chk(17, '0);
    d0 = done_cnt;
    a0 = ab_cnt;
    go(2'b00);
    to_rel(15);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    at_rel(16);
    checks++;
    if (busy !== 1'b1 || aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_entry: busy=%b aborted=%b want 1 0", busy, aborted);
    end
    at_rel(36);
    checks++;
    if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse36: aborted=%b busy=%b done=%b want 1 0 0", aborted, busy, done);
    end
    at_rel(40);
    checks++;
    if (ab_cnt - a0 != 1 || done_cnt - d0 != 0 || exp_q.size() != 0 || shreg !== '0) begin
      errors++;
      $display("FAIL abort_end: aborts=%0d dones=%0d left=%0d out=%h want 1 0 0 000",
               ab_cnt - a0, done_cnt - d0, exp_q.size(), shreg);
    end
  endtask

  task automatic test_start_stop();
    begin_scn();
    b0 = busy_cnt;
    n0 = nstr;
    @(posedge clk); #1;
    mode = 2'b00; start = 1'b1; stop = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    at_rel(12);
    checks++;
    if (nstr != n0 || busy_cnt != b0) begin
      errors++;
      $display("FAIL start_stop: strobes=%0d busy_cycles=%0d want 0 0", nstr - n0, busy_cnt - b0);
    end
  endtask

  task automatic test_back_to_back();
    begin_scn();
    push_seq(W, 1'b1, 1'b0);
    push_seq(W, 1'b1, 1'b1);
    push_seq(W, 1'b1, 1'b0);
    push_chk(20, 10'h3FF);
    d0 = done_cnt;
    go(2'b00);
    to_rel(5);
    start = 1'b1;
    mode  = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    at_rel(70);
    checks++;
    if (nstr - base != 30 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_ignored: strobes=%0d dones=%0d want 30 1", nstr - base, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    begin_scn();
    push_seq(4, 1'b1, 1'b0);
    d0 = done_cnt;
    go(2'b00);
    to_rel(9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    at_rel(10);
    checks++;
    if (busy !== 1'b0 || sh_enable !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid10: busy=%b sh_enable=%b want 0 0", busy, sh_enable);
    end
    at_rel(30);
    checks++;
    if (nstr - base != 4 || done_cnt - d0 != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_end: strobes=%0d dones=%0d want 4 0", nstr - base, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_fill(2'b00);
    test_fill(2'b01);
    test_bounce();
    test_abort();
    test_start_stop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/corrimiento_ctrl.md
Name: corrimiento_ctrl

Overview:
Sequencer for the 10-bit bidirectional shift register (inputs enable, dir, in) that drives the LED bar.
- Generates a prescaled shift tick.
- Drives `sh_enable`, `sh_dir` and `sh_in` to play one of three patterns: fill-left, fill-right or bouncing dot.
- Reports busy, done and abort status to the top-level control logic.
- Does not drive the shifter's reset; it clears the shifter by shifting zeros.

Parameters:
- WIDTH, 10, shifter length in bits; legal range 2..16.
- DIV, 25000000, clk cycles per shift step; minimum 1.
- SWEEPS, 3, number of right+left round trips in bounce mode; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a pattern; ignored while busy.
- stop  in  1  abort request; honoured in any non-IDLE state.
- mode  in  2  pattern select, sampled on an accepted start: 00 fill-left, 01 fill-right, 10 and 11 bounce.
- sh_enable  out  1  one-cycle shift strobe to the shifter.
- sh_dir  out  1  1 = in enters Out[0] and data moves toward Out[WIDTH-1]; 0 = in enters Out[WIDTH-1] and data moves toward Out[0].
- sh_in  out  1  serial bit shifted in on each strobe.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when an abort drain finishes.
- step  out  $clog2(WIDTH+1)  strobes completed in the current phase.

Behaviour:
- All outputs are registered. Reset forces state IDLE, prescaler 0, step 0, sweep count 0, and every output 0.
- In IDLE the prescaler is held at 0. Elsewhere it counts 0..DIV-1. `sh_enable` = 1 in the cycle the count wraps, so strobes occur every DIV cycles.
- Start accepted at cycle T: the FSM leaves IDLE at T+1 and the first strobe occurs at cycle T+DIV.
  - With DIV=1 the strobe is high every cycle from T+1.
- `sh_dir` and `sh_in` are constant for a whole phase and valid whenever `sh_enable` = 1. `step` resets to 0 on each phase entry.
- States and transitions (n = strobes in the phase):
  - IDLE -> CLEAR on start && !stop. Start and stop in the same cycle: stay in IDLE.
  - CLEAR: n=WIDTH, in=0; dir=1 for fill-left and bounce, dir=0 for fill-right. Next state: FILL for fill modes, INJECT for bounce.
  - FILL: n=WIDTH, in=1, same dir as CLEAR. Next state DRAIN.
  - DRAIN: n=WIDTH, in=0, same dir. Next state DONE.
  - INJECT: n=1, dir=1, in=1; the dot lands at Out[0]. Next state RIGHT.
  - RIGHT: n=WIDTH-1, dir=1, in=0; the dot reaches Out[WIDTH-1]. Next state LEFT.
  - LEFT: n=WIDTH-1, dir=0, in=0; the dot returns to Out[0]. Sweep count increments on exit. Next state is RIGHT if count < SWEEPS, else BCLR.
  - BCLR: n=1, dir=0, in=0; clears Out[0]. Next state DONE.
  - DONE: lasts 1 cycle with done=1 and busy=0, then IDLE.
  - ABORT: entered from any busy state when stop=1. Prescaler restarts at 0. n=WIDTH, dir=1, in=0. On completion, aborted=1 for 1 cycle and the FSM goes to IDLE (not DONE).
- A phase ends on the cycle its n-th strobe fires. The next state takes effect the following cycle. The prescaler continues without reset across phase boundaries, so strobe spacing stays exactly DIV.
- stop while in ABORT or DONE is ignored. start while busy is ignored, and mode changes while busy are ignored.
- rst asserted mid-pattern returns the FSM to IDLE next cycle. No done or aborted pulse is generated, and the shifter contents are left as they are.

Test Plan:
All scenarios use WIDTH=10, DIV=2, SWEEPS=2, instantiate the shifter (its reset held low after init), and apply start at cycle 0.
- Fill-left, mode 00:
  - 30 strobes at cycles 2,4,...,60.
  - Out=0x000 after strobe 10.
  - Out=0x001 after strobe 11.
  - Out=0x3FF after strobe 20.
  - Out=0x000 after strobe 30.
  - done=1 at cycle 61; busy=0 and back in IDLE at cycle 62.
- Fill-right, mode 01:
  - sh_dir=0 on all strobes.
  - Out=0x200 after strobe 11.
  - Out=0x3FF after strobe 20.
  - done at cycle 61.
- Bounce, mode 10:
  - 48 strobes in total.
  - Out=0x001 after strobe 11.
  - Out=0x200 after strobe 20.
  - Out=0x001 after strobe 29.
  - Out=0x000 after strobe 48.
  - done at cycle 97.
- Abort: stop at cycle 15 during fill-left:
  - ABORT entered at cycle 16.
  - 10 more strobes, at cycles 17,19,...,35.
  - aborted=1 at cycle 36; done never asserts.
  - Out=0x000 at the end.
- Corner cases:
  - start and stop together in IDLE -> no strobe, busy stays 0.
  - start at cycle 5 during a running pattern -> ignored; strobe count unchanged.
  - rst at cycle 9 -> busy=0 and sh_enable=0 from cycle 10; no done pulse.
